// File: rtl/sreg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the helper that classifies which operations advance the shift counter.
package sreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ASR  = 3'b101;
    localparam logic [2:0] MODE_LOAD = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Shift-class ops are the ones that count toward framing a word.
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
               (mode == MODE_ROL) || (mode == MODE_ASR);
    endfunction

endpackage

// File: rtl/sreg_bitcnt.sv
// Saturating shift counter that frames WIDTH-bit words: clear, increment,
// Full level and a one-cycle Done pulse on the edge the count reaches WIDTH.
module sreg_bitcnt #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_done;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (i_inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
            r_done  <= (r_count == CNT_LAST);
        end else begin
            // Saturated shifts, holds and idle cycles never raise Done.
            r_done  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CNT_MAX);
    assign o_done  = r_done;

endmodule

// File: rtl/sreg_univ.sv
// Universal shift register: shift/rotate/arithmetic-shift/load/clear per cycle,
// with a built-in word-framing counter for serialiser use.
module sreg_univ
    import sreg_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ShiftInR,
    input  logic             ShiftInL,
    output logic [WIDTH-1:0] Q,
    output logic             SerOutR,
    output logic             SerOutL,
    output logic [CNT_W-1:0] Count,
    output logic             Full,
    output logic             Done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    always_comb begin
        w_q_next = r_q;
        case (Mode)
            MODE_HOLD: w_q_next = r_q;
            MODE_SHR:  w_q_next = {ShiftInR, r_q[WIDTH-1:1]};
            MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], ShiftInL};
            MODE_ROR:  w_q_next = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ROL:  w_q_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            MODE_ASR:  w_q_next = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            MODE_LOAD: w_q_next = D;
            MODE_CLR:  w_q_next = '0;
            default:   w_q_next = r_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q <= RESET_VAL;
        end else if (Enable) begin
            r_q <= w_q_next;
        end
    end

    // Counter is gated by Enable here so the sub-module sees only real events.
    assign w_cnt_clr = Enable && ((Mode == MODE_LOAD) || (Mode == MODE_CLR));
    assign w_cnt_inc = Enable && is_shift(Mode);

    sreg_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .i_clk   (Clock),
        .i_rst   (Reset),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (Count),
        .o_full  (Full),
        .o_done  (Done)
    );

    assign Q       = r_q;
    assign SerOutR = r_q[0];
    assign SerOutL = r_q[WIDTH-1];

endmodule
